// File: rtl/mem_arb_pkg.sv
// Shared encodings and width defaults for the two-requester memory arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/mem_arb_grant.sv
// Two-way grant picker; MEM_ARB_ROUND_ROBIN_EN adds a last-grant pointer,
// otherwise the LSU has fixed priority.
module mem_arb_grant
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic clock,
    input  logic reset,
    input  logic fire,
`endif
    input  logic ifu_valid,
    input  logic lsu_valid,
    output logic grant
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic ptr;

    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr <= OWN_IFU;
        end else if (fire) begin
            ptr <= grant;
        end
    end

    // On a tie the requester that was not granted last time wins.
    always_comb begin
        grant = OWN_IFU;
        if (ifu_valid && lsu_valid) begin
            grant = ~ptr;
        end else if (lsu_valid) begin
            grant = OWN_LSU;
        end
    end
`else
    logic unused_ifu;
    assign unused_ifu = ifu_valid;
    assign grant      = lsu_valid ? OWN_LSU : OWN_IFU;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// IFU/LSU arbiter in front of a single memory port, one transaction in flight.
// Optional round-robin arbitration via MEM_ARB_ROUND_ROBIN_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ifu_kill,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_resp_valid,
    input  logic                ifu_resp_ready,
    output logic [DATA_W-1:0]   ifu_resp_data,
    output logic                ifu_resp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wstrb,
    output logic                lsu_resp_valid,
    input  logic                lsu_resp_ready,
    output logic [DATA_W-1:0]   lsu_resp_data,
    output logic                lsu_resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wstrb,
    input  logic                mem_resp_valid,
    output logic                mem_resp_ready,
    input  logic [DATA_W-1:0]   mem_resp_data,
    input  logic                mem_resp_err
);

    logic [1:0]          state;
    logic                owner;
    logic                drop;
    logic [ADDR_W-1:0]   buf_addr;
    logic                buf_wen;
    logic [DATA_W-1:0]   buf_wdata;
    logic [DATA_W/8-1:0] buf_wstrb;

    logic ifu_cand;
    logic grant;
    logic in_idle;
    logic in_resp;
    logic ifu_fire;
    logic lsu_fire;
    logic kill_hit;
    logic dropping;
    logic resp_fire;

    assign ifu_cand = ifu_req_valid && !ifu_kill;
    assign in_idle  = reset && (state == ST_IDLE);
    assign in_resp  = reset && (state == ST_RESP);

    mem_arb_grant u_grant (
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .clock     (clock),
        .reset     (reset),
        .fire      (ifu_fire || lsu_fire),
`endif
        .ifu_valid (ifu_cand),
        .lsu_valid (lsu_req_valid),
        .grant     (grant)
    );

    assign ifu_req_ready = in_idle && ifu_cand && (grant == OWN_IFU);
    assign lsu_req_ready = in_idle && lsu_req_valid && (grant == OWN_LSU);
    assign ifu_fire      = ifu_req_ready && ifu_req_valid;
    assign lsu_fire      = lsu_req_ready && lsu_req_valid;

    assign mem_req_valid = reset && (state == ST_REQ);
    assign mem_req_addr  = buf_addr;
    assign mem_req_wen   = buf_wen;
    assign mem_req_wdata = buf_wdata;
    assign mem_req_wstrb = buf_wstrb;

    // A kill arriving in the same cycle as the response must also drop it.
    assign kill_hit = ifu_kill && (owner == OWN_IFU);
    assign dropping = drop || kill_hit;

    assign ifu_resp_valid = in_resp && (owner == OWN_IFU) && !dropping
                            && mem_resp_valid;
    assign lsu_resp_valid = in_resp && (owner == OWN_LSU) && mem_resp_valid;
    assign ifu_resp_data  = mem_resp_data;
    assign ifu_resp_err   = mem_resp_err;
    assign lsu_resp_data  = mem_resp_data;
    assign lsu_resp_err   = mem_resp_err;

    always_comb begin
        mem_resp_ready = 1'b0;
        if (in_resp) begin
            if (owner == OWN_LSU) begin
                mem_resp_ready = lsu_resp_ready;
            end else begin
                mem_resp_ready = dropping || ifu_resp_ready;
            end
        end
    end

    assign resp_fire = in_resp && mem_resp_valid && mem_resp_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= ST_IDLE;
            owner     <= OWN_IFU;
            drop      <= 1'b0;
            buf_addr  <= '0;
            buf_wen   <= 1'b0;
            buf_wdata <= '0;
            buf_wstrb <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (ifu_fire) begin
                        buf_addr  <= ifu_req_addr;
                        buf_wen   <= 1'b0;
                        buf_wdata <= '0;
                        buf_wstrb <= '0;
                        owner     <= OWN_IFU;
                        drop      <= 1'b0;
                        state     <= ST_REQ;
                    end else if (lsu_fire) begin
                        buf_addr  <= lsu_req_addr;
                        buf_wen   <= lsu_req_wen;
                        buf_wdata <= lsu_req_wdata;
                        buf_wstrb <= lsu_req_wstrb;
                        owner     <= OWN_LSU;
                        drop      <= 1'b0;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (kill_hit) begin
                        drop <= 1'b1;
                    end
                    if (mem_req_ready) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (kill_hit) begin
                        drop <= 1'b1;
                    end
                    if (resp_fire) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction vector table plus kill and
// reset sequences; tie expectations follow MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

    logic        clock;
    logic        reset;
    logic        ifu_kill;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_resp_valid;
    logic        ifu_resp_ready;
    logic [31:0] ifu_resp_data;
    logic        ifu_resp_err;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_req_addr;
    logic        lsu_req_wen;
    logic [31:0] lsu_req_wdata;
    logic [3:0]  lsu_req_wstrb;
    logic        lsu_resp_valid;
    logic        lsu_resp_ready;
    logic [31:0] lsu_resp_data;
    logic        lsu_resp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic        mem_resp_ready;
    logic [31:0] mem_resp_data;
    logic        mem_resp_err;

    mem_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .ifu_kill       (ifu_kill),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_req_addr   (ifu_req_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_resp_ready (ifu_resp_ready),
        .ifu_resp_data  (ifu_resp_data),
        .ifu_resp_err   (ifu_resp_err),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_req_addr   (lsu_req_addr),
        .lsu_req_wen    (lsu_req_wen),
        .lsu_req_wdata  (lsu_req_wdata),
        .lsu_req_wstrb  (lsu_req_wstrb),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_resp_ready (lsu_resp_ready),
        .lsu_resp_data  (lsu_resp_data),
        .lsu_resp_err   (lsu_resp_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wen    (mem_req_wen),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wstrb  (mem_req_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_ready (mem_resp_ready),
        .mem_resp_data  (mem_resp_data),
        .mem_resp_err   (mem_resp_err)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic        ifu_v;
        logic [31:0] ifu_addr;
        logic        lsu_v;
        logic [31:0] lsu_addr;
        logic        lsu_wen;
        logic [31:0] lsu_wdata;
        logic [3:0]  lsu_wstrb;
        int          stall;
        int          delay;
        logic [31:0] rdata;
        logic        rerr;
        logic        exp_lsu;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset && mem_req_valid && mem_req_ready) hs_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [31:0] ia,
                                input logic lv, input logic [31:0] la,
                                input logic w, input logic [31:0] wd,
                                input logic [3:0] ws, input int st,
                                input int dl, input logic [31:0] rd,
                                input logic re, input logic el);
        vec_t v;
        v.ifu_v = iv;   v.ifu_addr = ia;
        v.lsu_v = lv;   v.lsu_addr = la;
        v.lsu_wen = w;  v.lsu_wdata = wd;  v.lsu_wstrb = ws;
        v.stall = st;   v.delay = dl;
        v.rdata = rd;   v.rerr = re;  v.exp_lsu = el;
        return v;
    endfunction

    task automatic idle_inputs();
        ifu_req_valid  = 1'b0;
        lsu_req_valid  = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        ifu_kill       = 1'b0;
    endtask

    // One complete transaction starting from IDLE; ends at a negedge in IDLE.
    task automatic run(input vec_t v);
        logic        own;
        logic [31:0] ea;
        logic        ew;
        logic [3:0]  es;
        int          h0;
        own = v.exp_lsu;
        ea  = own ? v.lsu_addr : v.ifu_addr;
        ew  = own ? v.lsu_wen : 1'b0;
        es  = own ? v.lsu_wstrb : 4'h0;
        @(negedge clock);
        ifu_kill      = 1'b0;
        ifu_req_valid = v.ifu_v;
        ifu_req_addr  = v.ifu_addr;
        lsu_req_valid = v.lsu_v;
        lsu_req_addr  = v.lsu_addr;
        lsu_req_wen   = v.lsu_wen;
        lsu_req_wdata = v.lsu_wdata;
        lsu_req_wstrb = v.lsu_wstrb;
        #1;
        chk("grant_ifu_ready", ifu_req_ready, v.ifu_v && !own);
        chk("grant_lsu_ready", lsu_req_ready, own);
        h0 = hs_cnt;
        @(negedge clock);
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        for (int i = 0; i <= v.stall; i++) begin
            #1;
            chk("mem_req_valid", mem_req_valid, 1'b1);
            chk("mem_req_addr", mem_req_addr, ea);
            chk("mem_req_wen", mem_req_wen, ew);
            chk("mem_req_wstrb", mem_req_wstrb, es);
            if (own) chk("mem_req_wdata", mem_req_wdata, v.lsu_wdata);
            chk("busy_ifu_ready", ifu_req_ready, 1'b0);
            chk("busy_lsu_ready", lsu_req_ready, 1'b0);
            mem_req_ready = (i == v.stall);
            @(negedge clock);
        end
        mem_req_ready = 1'b0;
        for (int j = 0; j < v.delay; j++) begin
            #1;
            chk("resp_wait_req_valid", mem_req_valid, 1'b0);
            chk("resp_wait_ifu_valid", ifu_resp_valid, 1'b0);
            chk("resp_wait_lsu_valid", lsu_resp_valid, 1'b0);
            @(negedge clock);
        end
        mem_resp_valid = 1'b1;
        mem_resp_data  = v.rdata;
        mem_resp_err   = v.rerr;
        ifu_resp_ready = 1'b1;
        lsu_resp_ready = 1'b1;
        #1;
        chk("ifu_resp_valid", ifu_resp_valid, !own);
        chk("lsu_resp_valid", lsu_resp_valid, own);
        chk("resp_data", own ? lsu_resp_data : ifu_resp_data, v.rdata);
        chk("resp_err", own ? lsu_resp_err : ifu_resp_err, v.rerr);
        chk("mem_resp_ready", mem_resp_ready, 1'b1);
        @(negedge clock);
        idle_inputs();
        chk("mem_handshakes", hs_cnt - h0, 1);
    endtask

    vec_t vecs[8];
    vec_t v;

    initial begin
        // Table: IFU read, 4 ties, LSU write, stalled IFU read, LSU read err
        vecs[0] = mk(1, 32'h3000_0000, 0, 32'h0, 0, 32'h0, 4'h0,
                     0, 2, 32'h0000_0413, 0, 0);
        for (int i = 0; i < 4; i++) begin
            vecs[1+i] = mk(1, 32'h3000_0100 + 32'(i * 4),
                           1, 32'h8000_0400 + 32'(i * 4),
                           0, 32'h0, 4'h0, 0, 1,
                           32'h1111_0000 + 32'(i), 0,
                           RR ? (i % 2 == 0) : 1'b1);
        end
        vecs[5] = mk(0, 32'h0, 1, 32'h8000_0010, 1, 32'hDEAD_BEEF, 4'hF,
                     0, 0, 32'h0, 0, 1);
        vecs[6] = mk(1, 32'h3000_0200, 0, 32'h0, 0, 32'h0, 4'h0,
                     5, 1, 32'h0050_0513, 0, 0);
        vecs[7] = mk(0, 32'h0, 1, 32'h8000_0020, 0, 32'h0, 4'h3,
                     1, 0, 32'h1234_5678, 1, 1);

        reset          = 1'b0;
        ifu_kill       = 1'b0;
        ifu_req_valid  = 1'b1;
        ifu_req_addr   = 32'h0;
        lsu_req_valid  = 1'b1;
        lsu_req_addr   = 32'h0;
        lsu_req_wen    = 1'b0;
        lsu_req_wdata  = 32'h0;
        lsu_req_wstrb  = 4'h0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0;
        mem_resp_err   = 1'b0;
        ifu_resp_ready = 1'b1;
        lsu_resp_ready = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_ifu_req_ready", ifu_req_ready, 1'b0);
        chk("rst_lsu_req_ready", lsu_req_ready, 1'b0);
        chk("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk("rst_ifu_resp_valid", ifu_resp_valid, 1'b0);
        chk("rst_lsu_resp_valid", lsu_resp_valid, 1'b0);
        chk("rst_mem_resp_ready", mem_resp_ready, 1'b0);
        idle_inputs();
        reset = 1'b1;

        for (int i = 0; i < 8; i++) run(vecs[i]);

        // Kill together with a request in IDLE: IFU not accepted, LSU can win
        @(negedge clock);
        ifu_req_valid = 1'b1;
        ifu_kill      = 1'b1;
        #1 chk("kill_idle_ifu_ready", ifu_req_ready, 1'b0);
        lsu_req_valid = 1'b1;
        #1 chk("kill_idle_lsu_ready", lsu_req_ready, 1'b1);
        idle_inputs();

        // Kill pulsed in RESP, response arrives 3 cycles later
        @(negedge clock);
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h3000_0040;
        #1 chk("kill_accept", ifu_req_ready, 1'b1);
        @(negedge clock);
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1 chk("kill_mem_req_valid", mem_req_valid, 1'b1);
        @(negedge clock);
        mem_req_ready = 1'b0;
        ifu_kill      = 1'b1;
        #1 chk("kill_resp_wait", ifu_resp_valid, 1'b0);
        @(negedge clock);
        ifu_kill = 1'b0;
        repeat (2) @(negedge clock);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0000_0BAD;
        ifu_resp_ready = 1'b0;
        #1;
        chk("drop_mem_resp_ready", mem_resp_ready, 1'b1);
        chk("drop_ifu_resp_valid", ifu_resp_valid, 1'b0);
        chk("drop_lsu_resp_valid", lsu_resp_valid, 1'b0);
        @(negedge clock);
        idle_inputs();
        v = mk(1, 32'h3000_0044, 0, 32'h0, 0, 32'h0, 4'h0,
               0, 0, 32'h0010_0073, 0, 0);
        run(v);

        // Reset asserted while the request sits in REQ
        @(negedge clock);
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 32'h8000_0200;
        lsu_req_wen   = 1'b0;
        #1 chk("rst_txn_accept", lsu_req_ready, 1'b1);
        @(negedge clock);
        ifu_req_valid = 1'b1;
        reset         = 1'b0;
        #1;
        chk("rst_txn_mem_valid", mem_req_valid, 1'b0);
        chk("rst_txn_ifu_ready", ifu_req_ready, 1'b0);
        chk("rst_txn_lsu_ready", lsu_req_ready, 1'b0);
        @(negedge clock);
        mem_resp_valid = 1'b1;
        #1;
        chk("rst_txn_lsu_resp", lsu_resp_valid, 1'b0);
        chk("rst_txn_mem_resp_ready", mem_resp_ready, 1'b0);
        idle_inputs();
        reset = 1'b1;
        #1 chk("rst_release_mem_valid", mem_req_valid, 1'b0);
        v = mk(0, 32'h0, 1, 32'h8000_0300, 0, 32'h0, 4'h0,
               0, 1, 32'hCAFE_F00D, 0, 1);
        run(v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester memory arbiter between the instruction fetch path (IFU/ICU side) and the load-store unit, in front of the single shared memory port.
- Accepts one request at a time, latches it, and drives it to memory with one transaction outstanding.
- Returns the response to the requester that owns the transaction.
- Discards IFU responses whose fetch was killed by a pipeline flush (exception, mret or branch redirect).

## Interface
Parameters:
- ADDR_W, 32, request address width
- DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- ifu_kill  in  1  OR of excp_flush, mret_flush and branch_flush
- ifu_req_valid / ifu_req_ready  in / out  1  IFU request handshake
- ifu_req_addr  in  ADDR_W  fetch address
- ifu_resp_valid / ifu_resp_ready  out / in  1  IFU response handshake
- ifu_resp_data  out  DATA_W  fetched word
- ifu_resp_err  out  1  bus error
- lsu_req_valid / lsu_req_ready  in / out  1  LSU request handshake
- lsu_req_addr  in  ADDR_W  address
- lsu_req_wen  in  1  write when 1
- lsu_req_wdata  in  DATA_W  write data
- lsu_req_wstrb  in  DATA_W/8  byte strobes
- lsu_resp_valid / lsu_resp_ready  out / in  1  LSU response handshake
- lsu_resp_data  out  DATA_W  read data (don't-care on writes)
- lsu_resp_err  out  1  bus error
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake
- mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb  out  as LSU  request fields
- mem_resp_valid / mem_resp_ready  in / out  1  memory response handshake
- mem_resp_data  in  DATA_W  response data
- mem_resp_err  in  1  response error

## Operation
FSM states: IDLE, REQ, RESP. Owner register is IFU or LSU.

IDLE:
- Pick a winner among valid requesters (see Configuration).
- Only the winner's req_ready is 1; all other req_ready are 0.
- ifu_req_ready is forced to 0 while ifu_kill is 1.
- On the handshake: latch addr, wen, wdata and wstrb into a request buffer, set owner, clear drop, and go to REQ.
- IFU requests are latched with wen=0 and wstrb=0.

REQ:
- mem_req_valid=1, driven from the request buffer.
- On mem_req_ready, go to RESP.

RESP:
- mem_resp_valid is routed to the owner's resp_valid, together with data and err.
- mem_resp_ready follows the owner's resp_ready.
- On the response handshake, return to IDLE.

Kill:
- ifu_kill while owner=IFU in REQ or RESP sets the drop register.
- The memory transaction still completes.
- While drop is set (or ifu_kill is high in the same cycle), ifu_resp_valid=0 and mem_resp_ready=1, and the response is consumed silently.
- ifu_kill has no effect while owner=LSU.

Other rules:
- The non-owner's resp_valid is always 0.
- At most one mem transaction is outstanding at any time.

## Timing
- Reset (reset=0 at a clock edge): state=IDLE, owner=IFU, drop=0, rr pointer=IFU.
- All valid and ready outputs are 0 while reset is held low, including req_ready.
- Reset mid-transaction abandons the transaction; memory is reset in the same domain.
- Request accepted in cycle T; mem_req_valid is first high in T+1.
- mem_req_* stays stable until mem_req_ready.
- Response path is combinational: mem_resp_valid at T+k gives owner resp_valid at T+k.
- Minimum round trip: accept T, mem accept T+1, response T+2, next accept T+3.
- No back-to-back accept without passing through IDLE.
- Simultaneous ifu_kill and mem_resp_valid in RESP: the response is dropped.
- Simultaneous ifu_kill and ifu_req_valid in IDLE: not accepted; the LSU may win that cycle.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined:
  - A 1-bit pointer records the last granted requester.
  - On a simultaneous request, the other requester wins.
  - The pointer updates on every request handshake.
- MEM_ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority: LSU always wins a simultaneous request.
  - No pointer register exists.

## Structure
- Shared package mem_arb_pkg holds:
  - the state encoding (IDLE/REQ/RESP)
  - the owner encoding (OWN_IFU=0, OWN_LSU=1)
  - the ADDR_W/DATA_W defaults
- One sub-module, mem_arb_grant: two-way grant picker with optional round-robin pointer, combinational grant plus pointer register.

## Test plan
- IFU-only read, addr 0x30000000, memory returns 0x00000413 after 2 cycles -> ifu_resp_data=0x00000413, err=0; lsu_resp_valid never high.
- LSU write addr 0x80000010, wdata 0xDEADBEEF, wstrb 0xF -> mem_req carries the identical fields for exactly one handshake; lsu_resp_valid=1 when memory responds.
- IFU and LSU valid in the same cycle, repeated 4 times:
  - with macro: grants alternate LSU, IFU, LSU, IFU (pointer starts at IFU);
  - without macro: LSU wins every time.
- ifu_kill pulsed in RESP while memory holds the response 3 cycles -> mem_resp_ready=1 on arrival, ifu_resp_valid stays 0, state returns to IDLE, next IFU request is accepted.
- mem_req_ready held low 5 cycles -> mem_req_* stable and both req_ready stay 0 throughout.
- reset driven low in REQ -> next cycle all valids 0, state IDLE; after release, a new LSU read completes normally.
